// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// Module   : alu_issue_ctrl
// Brief    : Decode/issue stage for the 16-bit ALU with a single-entry ID/EX
//            register. Optional multiply support: ALU_ISSUE_MUL_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_ctrl #(
    parameter int INST_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [INST_SIZE-1:0] i_instr,
    input  logic [INST_SIZE-1:0] i_rd_data,
    input  logic [INST_SIZE-1:0] i_rs_data,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [2:0]           o_alu_ctrl,
    output logic [INST_SIZE-1:0] o_in0,
    output logic [INST_SIZE-1:0] o_in1,
    output logic                 o_wr_en,
    output logic [2:0]           o_dest,
    output logic                 o_is_branch,
    output logic                 o_illegal,
    output logic [15:0]          o_issue_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
`ifdef ALU_ISSUE_MUL_EN
        S_SETTLE = 2'd1,
`endif
        S_HOLD   = 2'd2
    } state_t;

    state_t                 r_state;
    logic                   r_out_valid;
    logic [2:0]             r_alu_ctrl;
    logic [INST_SIZE-1:0]   r_in0;
    logic [INST_SIZE-1:0]   r_in1;
    logic                   r_wr_en;
    logic [2:0]             r_dest;
    logic                   r_is_branch;
    logic                   r_illegal;
    logic [15:0]            r_issue_cnt;

    logic                   w_legal;
`ifdef ALU_ISSUE_MUL_EN
    logic                   w_mul;
`endif
    logic [2:0]             w_ctrl;
    logic [INST_SIZE-1:0]   w_in1;
    logic                   w_wr_en;
    logic                   w_is_branch;
    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_fire;
    logic                   w_unused_rs;

    wire [3:0] w_opcode = i_instr[15:12];
    wire [2:0] w_funct  = i_instr[2:0];
    wire [INST_SIZE-1:0] w_imm = {{(INST_SIZE-6){i_instr[5]}}, i_instr[5:0]};

    // The rs field is already resolved into i_rs_data by the register file.
    assign w_unused_rs = ^i_instr[8:6];

    always_comb begin
        w_legal     = 1'b0;
`ifdef ALU_ISSUE_MUL_EN
        w_mul       = 1'b0;
`endif
        w_ctrl      = 3'b000;
        w_in1       = i_rs_data;
        w_wr_en     = 1'b0;
        w_is_branch = 1'b0;
        case (w_opcode)
            4'b0000: begin
                w_ctrl  = w_funct;
                w_wr_en = 1'b1;
                case (w_funct)
                    3'b110, 3'b111: w_legal = 1'b0;
                    3'b101: begin
`ifdef ALU_ISSUE_MUL_EN
                        w_legal = 1'b1;
                        w_mul   = 1'b1;
`else
                        w_legal = 1'b0;
`endif
                    end
                    default: w_legal = 1'b1;
                endcase
            end
            4'b0100: begin
                w_legal = 1'b1;
                w_in1   = w_imm;
                w_wr_en = 1'b1;
            end
            4'b1000: begin
                w_legal     = 1'b1;
                w_ctrl      = 3'b001;
                w_is_branch = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_HOLD) && i_out_ready);
    assign w_accept   = i_in_valid && w_in_ready;
    assign w_fire     = r_out_valid && i_out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_alu_ctrl  <= 3'b000;
            r_in0       <= '0;
            r_in1       <= '0;
            r_wr_en     <= 1'b0;
            r_dest      <= 3'b000;
            r_is_branch <= 1'b0;
            r_illegal   <= 1'b0;
            r_issue_cnt <= 16'h0000;
        end else begin
            r_illegal <= w_accept && !w_legal;
            if (w_fire) begin
                r_issue_cnt <= r_issue_cnt + 16'h0001;
            end
            case (r_state)
`ifdef ALU_ISSUE_MUL_EN
                S_SETTLE: begin
                    r_state     <= S_HOLD;
                    r_out_valid <= 1'b1;
                end
`endif
                default: begin
                    // IDLE and HOLD share the load path; illegal ops never load.
                    if (w_accept && w_legal) begin
                        r_alu_ctrl  <= w_ctrl;
                        r_in0       <= i_rd_data;
                        r_in1       <= w_in1;
                        r_wr_en     <= w_wr_en;
                        r_dest      <= i_instr[11:9];
                        r_is_branch <= w_is_branch;
`ifdef ALU_ISSUE_MUL_EN
                        if (w_mul) begin
                            r_state     <= S_SETTLE;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_state     <= S_HOLD;
                            r_out_valid <= 1'b1;
                        end
`else
                        r_state     <= S_HOLD;
                        r_out_valid <= 1'b1;
`endif
                    end else if (w_fire || (r_state != S_HOLD)) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_alu_ctrl  = r_alu_ctrl;
    assign o_in0       = r_in0;
    assign o_in1       = r_in1;
    assign o_wr_en     = r_wr_en;
    assign o_dest      = r_dest;
    assign o_is_branch = r_is_branch;
    assign o_illegal   = r_illegal;
    assign o_issue_cnt = r_issue_cnt;

endmodule

`default_nettype wire

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

- Decode/issue stage that drives the 16-bit datapath ALU.
- Accepts one instruction word plus its two register-file read values over a valid/ready handshake, and decodes the opcode/funct fields into the 3-bit ALU control code.
- Holds the operation in a single-entry ID/EX register and presents it to the ALU (and downstream writeback/branch logic) over a second valid/ready handshake.
- Multiply operations get one extra settle cycle before issue.

## Interface
- `inst_SIZE`, 16, datapath and instruction width
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  instruction + operands valid
- `in_ready`  out  1  stage can accept
- `instr`  in  inst_SIZE  `[15:12]` opcode, `[11:9]` rd, `[8:6]` rs, `[5:0]` imm6 / `[2:0]` funct
- `rd_data`  in  inst_SIZE  register value at rd
- `rs_data`  in  inst_SIZE  register value at rs
- `out_valid`  out  1  issued op valid
- `out_ready`  in  1  consumer accepts issued op
- `ALU_ctrl`  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 mul
- `in0`  out  inst_SIZE  ALU operand 0
- `in1`  out  inst_SIZE  ALU operand 1
- `wr_en`  out  1  result writes rd
- `dest`  out  3  destination register
- `is_branch`  out  1  op is beq (consumer uses ALU zero)
- `illegal`  out  1  one-cycle pulse: undecodable instruction dropped
- `issue_cnt`  out  16  count of completed output handshakes

## Operation
- Decode:
  - opcode 0000 (R-type): `ALU_ctrl=funct`; `in0=rd_data`, `in1=rs_data`; `wr_en=1`. funct 110/111 are illegal.
  - opcode 0100 (addi): `ALU_ctrl=000`; `in0=rd_data`, `in1=sign-extended imm6`; `wr_en=1`.
  - opcode 1000 (beq): `ALU_ctrl=001`; `in0=rd_data`, `in1=rs_data`; `wr_en=0`, `is_branch=1`.
  - All other opcodes are illegal.
- `dest=instr[11:9]` for every legal op.
- States:
  - IDLE: no op held.
  - SETTLE: mul held, `out_valid=0`, operands driven.
  - HOLD: `out_valid=1`.
- Transitions:
  - IDLE: legal non-mul accepted → HOLD; mul accepted → SETTLE; illegal accepted → IDLE.
  - SETTLE → HOLD unconditionally.
  - HOLD & `out_ready`: a new legal accept loads the new op (→ HOLD, or → SETTLE for mul); otherwise → IDLE. An illegal accept in this cycle also → IDLE.
- `in_ready = (state==IDLE) | (state==HOLD & out_ready)`. It is 0 in SETTLE.
- Illegal accept: the op is discarded, held outputs are unchanged, and `illegal` is high for the following cycle.
- `issue_cnt` increments on each `out_valid & out_ready`. It wraps FFFF → 0000.
- Held outputs (`ALU_ctrl`, `in0`, `in1`, `wr_en`, `dest`, `is_branch`) are registered and stable while `out_valid=1 & out_ready=0`.

## Timing
- Reset values: state IDLE, `in_ready=1`, `out_valid=0`, `ALU_ctrl=000`, `in0`/`in1`=0, `wr_en=0`, `dest=0`, `is_branch=0`, `illegal=0`, `issue_cnt=0`.
- Latency, non-mul: accepted at edge N → `out_valid=1` after edge N (one cycle).
- Latency, mul: SETTLE after edge N, `out_valid=1` after edge N+1.
- Throughput: one op/cycle for back-to-back non-mul with `out_ready=1`. Mul costs 2 cycles.
- Reset asserted mid-operation (any state) clears the held op, the counter and the pulse immediately, with no output handshake. First accept is possible on the first rising edge after `rst_n` deasserts.
- `out_ready` asserted while `out_valid=0` has no effect.

## Configuration
- `ALU_ISSUE_MUL_EN` defined: funct 101 decodes as mul and uses the SETTLE cycle.
- `ALU_ISSUE_MUL_EN` undefined: funct 101 is illegal (pulses `illegal`, not issued), and the SETTLE state is not built.

## Test plan
- Reset → all outputs at reset values, `in_ready=1`. Then add (`instr=0x0040`, `rd_data=5`, `rs_data=7`) → `out_valid` next cycle, `ALU_ctrl=000`, `in0=5`, `in1=7`, `wr_en=1`, `dest=0`.
- addi `instr=0x423F` (rd=1, imm=-1) → `ALU_ctrl=000`, `in1=0xFFFF`, `dest=1`. beq `instr=0x8000` → `ALU_ctrl=001`, `is_branch=1`, `wr_en=0`.
- mul (funct 101) with `out_ready=1` → `in_ready=0` for one cycle, `out_valid` two cycles after accept. With the macro undefined → `illegal` pulse, no `out_valid`.
- Backpressure: `out_ready=0` for 3 cycles with a new `in_valid` → `in_ready=0`, outputs stable. Raise `out_ready` → same-edge handoff to the new op, `issue_cnt` +1.
- Opcode 1111 → `illegal=1` for exactly one cycle, `issue_cnt` unchanged, `out_valid=0`.
- Preload `issue_cnt` to FFFF via 65535 handshakes (or force) plus one more → `0000`. Assert `rst_n=0` while in HOLD → `out_valid` drops immediately.
